// File: rtl/ppu_vbuf_writer_pkg.sv
// Shared constants and types for the PPU video-buffer write side.
// The LCD reader uses the same address layout and page-bit position.
package ppu_vbuf_writer_pkg;

    localparam int VBUF_AW     = 17;   // {page, y[7:0], x[7:0]}
    localparam int VBUF_DW     = 8;    // {1'b0, hsv[6:0]}
    localparam int PAGE_BIT    = 16;
    localparam int H_PIX_DEF   = 256;
    localparam int V_LINES_DEF = 240;
    localparam int HSV_W       = 7;
    localparam int ENTRY_W     = 24;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } wr_state_e;

    // One queued vbuf write, frozen at push time.
    typedef struct packed {
        logic       page;
        logic [7:0] y;
        logic [7:0] x;
        logic [6:0] hsv;
    } vbuf_entry_t;

    function automatic logic [VBUF_AW-1:0] entry_addr(input vbuf_entry_t e);
        return {e.page, e.y, e.x};
    endfunction

    function automatic logic [VBUF_DW-1:0] entry_data(input vbuf_entry_t e);
        return {1'b0, e.hsv};
    endfunction

endpackage

// File: rtl/ppu_vbuf_fifo.sv
// Synchronous FIFO between the pixel stream and the vbuf write port.
// Flags are decoded from a registered occupancy count only.
module ppu_vbuf_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           wdata,
    input  logic                   pop,
    output logic [W-1:0]           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Pointer and occupancy update; pointers wrap naturally (power-of-two depth).
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end

    // Storage array; contents need no reset, occupancy guards every read.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ppu_vbuf_writer.sv
// Write side of the double-buffered PPU video buffer: raster tracking,
// page selection and frame sequencing in front of a small write FIFO.
module ppu_vbuf_writer
    import ppu_vbuf_writer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int H_PIX      = H_PIX_DEF,
    parameter int V_LINES    = V_LINES_DEF
) (
    input  logic               i_ppu_clk,
    input  logic               i_ppu_rst,
    input  logic               i_frame_start,
    input  logic               i_pix_vld,
    output logic               o_pix_rdy,
    input  logic [HSV_W-1:0]   i_pix_hsv,
    output logic [VBUF_AW-1:0] o_vbuf_addr,
    output logic [VBUF_DW-1:0] o_vbuf_data,
    output logic               o_vbuf_we,
    input  logic               i_vbuf_wrdy,
    output logic               o_wr_page,
    output logic               o_frame_done,
    output logic               o_frame_abort,
    output logic               o_pix_drop,
    input  logic               i_clr_err
);

    localparam logic [7:0] X_LAST = 8'(H_PIX - 1);
    localparam logic [7:0] Y_LAST = 8'(V_LINES - 1);
    localparam int         CW     = $clog2(FIFO_DEPTH) + 1;

    wr_state_e   state_q, state_d;
    logic [7:0]  x_q, x_d, y_q, y_d;
    logic        page_q, page_d;
    logic        done_q, done_d;
    logic        abort_q, abort_d;
    logic        drop_q, drop_d;

    logic        pix_hs, push, pop, drop_evt, pix_active;
    logic [7:0]  cur_x, cur_y;
    vbuf_entry_t push_entry, head_entry;
    logic        fifo_full, fifo_empty;
    logic [CW-1:0] fifo_cnt;

    ppu_vbuf_fifo #(.DEPTH(FIFO_DEPTH), .W(ENTRY_W)) u_fifo (
        .clk   (i_ppu_clk),
        .rst   (i_ppu_rst),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign o_pix_rdy     = ~fifo_full;
    assign pix_hs        = i_pix_vld & ~fifo_full;
    assign o_vbuf_we     = ~fifo_empty;
    assign pop           = o_vbuf_we & i_vbuf_wrdy;
    // Idle bus reads as zero so stale array contents never leak out.
    assign o_vbuf_addr   = fifo_empty ? '0 : entry_addr(head_entry);
    assign o_vbuf_data   = fifo_empty ? '0 : entry_data(head_entry);
    assign o_wr_page     = page_q;
    assign o_frame_done  = done_q;
    assign o_frame_abort = abort_q;
    assign o_pix_drop    = drop_q;

    // Frame FSM, raster counters and page toggle; a frame start is applied
    // before the same-cycle pixel so that pixel lands at (0,0) of the new page.
    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        abort_d    = 1'b0;
        done_d     = 1'b0;
        push       = 1'b0;
        drop_evt   = 1'b0;
        pix_active = (state_q == ST_ACTIVE);
        cur_x      = x_q;
        cur_y      = y_q;

        if (i_frame_start) begin
            abort_d    = (state_q != ST_IDLE);
            state_d    = ST_ACTIVE;
            page_d     = ~page_q;
            pix_active = 1'b1;
            cur_x      = '0;
            cur_y      = '0;
        end

        x_d        = cur_x;
        y_d        = cur_y;
        push_entry = '{page: page_d, y: cur_y, x: cur_x, hsv: i_pix_hsv};

        if (pix_hs) begin
            if (pix_active) begin
                push = 1'b1;
                if (cur_x == X_LAST) begin
                    x_d = '0;
                    if (cur_y == Y_LAST) state_d = ST_DONE;
                    else                 y_d     = cur_y + 8'd1;
                end else begin
                    x_d = cur_x + 8'd1;
                end
            end else begin
                drop_evt = 1'b1;
            end
        end

        // Done fires once the FIFO is (or is about to be) empty so the pulse
        // lands the cycle after the frame's final vbuf write.
        if (state_q == ST_DONE && !i_frame_start &&
            (fifo_empty || (fifo_cnt == CW'(1) && pop))) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
        end

        // A new drop outranks a same-cycle clear.
        drop_d = drop_evt ? 1'b1 : (i_clr_err ? 1'b0 : drop_q);
    end

    // Control registers; page resets to 1 so the first frame fills page 0.
    always_ff @(posedge i_ppu_clk) begin
        if (i_ppu_rst) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            page_q  <= 1'b1;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            page_q  <= page_d;
            done_q  <= done_d;
            abort_q <= abort_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_ppu_vbuf_writer.sv
// Self-checking bench for ppu_vbuf_writer: a queue-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
// A short frame height keeps full-frame scenarios brief.
module tb_ppu_vbuf_writer;

    localparam int H = 256;
    localparam int V = 6;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        i_ppu_rst, i_frame_start, i_pix_vld, i_vbuf_wrdy, i_clr_err;
    logic [6:0]  i_pix_hsv;
    logic        o_pix_rdy, o_vbuf_we, o_wr_page, o_frame_done, o_frame_abort, o_pix_drop;
    logic [16:0] o_vbuf_addr;
    logic [7:0]  o_vbuf_data;

    ppu_vbuf_writer #(.FIFO_DEPTH(D), .H_PIX(H), .V_LINES(V)) dut (
        .i_ppu_clk     (clk),
        .i_ppu_rst     (i_ppu_rst),
        .i_frame_start (i_frame_start),
        .i_pix_vld     (i_pix_vld),
        .o_pix_rdy     (o_pix_rdy),
        .i_pix_hsv     (i_pix_hsv),
        .o_vbuf_addr   (o_vbuf_addr),
        .o_vbuf_data   (o_vbuf_data),
        .o_vbuf_we     (o_vbuf_we),
        .i_vbuf_wrdy   (i_vbuf_wrdy),
        .o_wr_page     (o_wr_page),
        .o_frame_done  (o_frame_done),
        .o_frame_abort (o_frame_abort),
        .o_pix_drop    (o_pix_drop),
        .i_clr_err     (i_clr_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int done_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] hsv_of(input int p);
        int x, y;
        x = p % H;
        y = p / H;
        return 7'((x ^ y) & 'h7F);
    endfunction

    // ---------------- reference model ----------------
    // States: 0 idle, 1 active, 2 done. Queue holds pending (addr, data) writes.
    int m_qa[$];
    int m_qd[$];
    int m_st, m_x, m_y, m_prev;
    bit m_page, m_done, m_abort, m_drop, armed = 0;
    bit m_rdy, m_hs, m_pop, m_dropev;

    always @(negedge clk) begin
        if (armed) begin
            chk("pix_rdy", 32'(o_pix_rdy), 32'(m_qa.size() < D));
            chk("vbuf_we", 32'(o_vbuf_we), 32'(m_qa.size() > 0));
            if (m_qa.size() > 0) begin
                chk("vbuf_addr", 32'(o_vbuf_addr), m_qa[0]);
                chk("vbuf_data", 32'(o_vbuf_data), m_qd[0]);
            end
            chk("wr_page", 32'(o_wr_page), 32'(m_page));
            chk("frame_done", 32'(o_frame_done), 32'(m_done));
            chk("frame_abort", 32'(o_frame_abort), 32'(m_abort));
            chk("pix_drop", 32'(o_pix_drop), 32'(m_drop));
            if (o_frame_done === 1'b1) done_cnt++;
        end
        if (i_ppu_rst) begin
            m_qa.delete(); m_qd.delete();
            m_st = 0; m_x = 0; m_y = 0; m_page = 1;
            m_done = 0; m_abort = 0; m_drop = 0;
            armed = 1;
        end else if (armed) begin
            m_prev   = m_st;
            m_rdy    = (m_qa.size() < D);
            m_hs     = i_pix_vld && m_rdy;
            m_pop    = (m_qa.size() > 0) && i_vbuf_wrdy;
            m_dropev = 0;
            m_done   = 0;
            m_abort  = 0;
            if (i_frame_start) begin
                m_abort = (m_st != 0);
                m_st = 1; m_x = 0; m_y = 0;
                m_page = ~m_page;
            end
            if (m_pop) begin
                void'(m_qa.pop_front());
                void'(m_qd.pop_front());
            end
            if (m_hs) begin
                if (m_st == 1) begin
                    m_qa.push_back(int'(m_page) * 65536 + m_y * 256 + m_x);
                    m_qd.push_back(int'(i_pix_hsv));
                    m_x++;
                    if (m_x == H) begin
                        m_x = 0;
                        m_y++;
                        if (m_y == V) m_st = 2;
                    end
                end else begin
                    m_dropev = 1;
                end
            end
            if (m_dropev)       m_drop = 1;
            else if (i_clr_err) m_drop = 0;
            if (!i_frame_start && m_prev == 2 && m_qa.size() == 0) begin
                m_done = 1;
                m_st = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one pixel until it handshakes; optionally randomise write-ready.
    task automatic send(input logic [6:0] hsv, input bit rnd);
        int  n;
        bit  hs;
        i_pix_vld = 1'b1;
        i_pix_hsv = hsv;
        n = 0;
        do begin
            if (rnd) i_vbuf_wrdy = 1'($urandom_range(0, 1));
            hs = o_pix_rdy;
            step();
            n++;
        end while (!hs && n < 50);
        i_pix_vld = 1'b0;
        if (!hs) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_done(input int n);
        int k;
        k = 0;
        while (done_cnt < n && k < 20) begin
            step();
            k++;
        end
        chk("frame_done_count", done_cnt, n);
        repeat (3) step();
        chk("frame_done_single", done_cnt, n);
    endtask

    task automatic frame_start();
        i_frame_start = 1'b1;
        step();
        i_frame_start = 1'b0;
    endtask

    initial begin
        int p;
        bit hs;
        i_ppu_rst = 1'b1; i_frame_start = 1'b0; i_pix_vld = 1'b0;
        i_pix_hsv = '0;   i_vbuf_wrdy = 1'b1;   i_clr_err = 1'b0;
        repeat (3) step();
        i_ppu_rst = 1'b0;

        // reset state
        chk("rst_rdy",   32'(o_pix_rdy), 1);
        chk("rst_we",    32'(o_vbuf_we), 0);
        chk("rst_addr",  32'(o_vbuf_addr), 0);
        chk("rst_data",  32'(o_vbuf_data), 0);
        chk("rst_page",  32'(o_wr_page), 1);
        chk("rst_done",  32'(o_frame_done), 0);
        chk("rst_abort", 32'(o_frame_abort), 0);
        chk("rst_drop",  32'(o_pix_drop), 0);

        // pixels in IDLE are dropped; clear loses to a simultaneous drop
        send(7'h05, 0);
        chk("idle_drop", 32'(o_pix_drop), 1);
        chk("idle_no_write", 32'(o_vbuf_we), 0);
        i_clr_err = 1'b1;
        send(7'h06, 0);
        i_clr_err = 1'b0;
        chk("clr_vs_drop", 32'(o_pix_drop), 1);
        i_clr_err = 1'b1;
        step();
        i_clr_err = 1'b0;
        chk("clr_err", 32'(o_pix_drop), 0);

        // frame 1 -> page 0, plus one surplus pixel
        frame_start();
        chk("f1_page", 32'(o_wr_page), 0);
        for (int i = 0; i < H * V; i++) begin
            send(hsv_of(i), 0);
            if (i == 1) begin
                chk("f1_addr_1", 32'(o_vbuf_addr), 32'h00001);
                chk("f1_data_1", 32'(o_vbuf_data), 32'h01);
            end
            if (i == 300) begin
                chk("f1_addr_300", 32'(o_vbuf_addr), 32'h0012C);
                chk("f1_data_300", 32'(o_vbuf_data), 32'h2D);
            end
        end
        chk("no_early_done", done_cnt, 0);
        send(7'h11, 0);
        chk("extra_drop", 32'(o_pix_drop), 1);
        wait_done(1);
        i_clr_err = 1'b1;
        step();
        i_clr_err = 1'b0;

        // frame 2 -> page 1
        frame_start();
        chk("f2_page", 32'(o_wr_page), 1);
        for (int i = 0; i < H * V; i++) begin
            send(hsv_of(i), 0);
            if (i == 1) chk("f2_addr_1", 32'(o_vbuf_addr), 32'h10001);
        end
        wait_done(2);

        // frame 3 -> page 0, with back-pressure
        frame_start();
        chk("f3_page", 32'(o_wr_page), 0);
        i_vbuf_wrdy = 1'b0;
        i_pix_vld = 1'b1;
        p = 0;
        for (int k = 0; k < 10; k++) begin
            i_pix_hsv = hsv_of(p);
            hs = o_pix_rdy;
            step();
            if (hs) p++;
        end
        i_pix_vld = 1'b0;
        chk("stall_pushes", p, D);
        chk("stall_rdy", 32'(o_pix_rdy), 0);
        chk("stall_addr", 32'(o_vbuf_addr), 32'h00000);
        i_vbuf_wrdy = 1'b1;
        repeat (6) step();
        chk("drained_we", 32'(o_vbuf_we), 0);
        for (int i = D; i < 1000; i++) send(hsv_of(i), 1);

        // abort mid-frame
        i_vbuf_wrdy = 1'b1;
        frame_start();
        chk("abort_pulse", 32'(o_frame_abort), 1);
        chk("abort_page", 32'(o_wr_page), 1);
        step();
        chk("abort_single", 32'(o_frame_abort), 0);
        repeat (6) step();
        send(7'h55, 0);
        chk("after_abort_addr", 32'(o_vbuf_addr), 32'h10000);
        chk("after_abort_data", 32'(o_vbuf_data), 32'h55);

        // frame start and pixel in the same cycle
        i_frame_start = 1'b1;
        send(7'h33, 0);
        i_frame_start = 1'b0;
        chk("sim_abort", 32'(o_frame_abort), 1);
        chk("sim_page", 32'(o_wr_page), 0);
        chk("sim_addr", 32'(o_vbuf_addr), 32'h00000);
        chk("sim_data", 32'(o_vbuf_data), 32'h33);
        chk("no_done_on_abort", done_cnt, 2);

        // reset mid-frame flushes queued writes
        i_vbuf_wrdy = 1'b0;
        for (int i = 0; i < 3; i++) send(7'(i + 8), 0);
        chk("pre_rst_we", 32'(o_vbuf_we), 1);
        i_ppu_rst = 1'b1;
        step();
        chk("mrst_we", 32'(o_vbuf_we), 0);
        chk("mrst_page", 32'(o_wr_page), 1);
        chk("mrst_rdy", 32'(o_pix_rdy), 1);
        i_ppu_rst = 1'b0;
        i_vbuf_wrdy = 1'b1;
        repeat (2) step();
        chk("mrst_idle_we", 32'(o_vbuf_we), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
